// File: rtl/ysyx_22041752_icache_sa.sv
// ============================================================================
// Module   : ysyx_22041752_icache_sa
// Brief    : N-way set-associative instruction cache with burst refill FSM.
//            Define YSYX_22041752_ICACHE_PLRU_EN for per-set tree-PLRU
//            replacement; otherwise a global round-robin counter is used.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22041752_icache_sa #(
  parameter int WAYS        = 2,
  parameter int SETS        = 64,
  parameter int LINE_BYTES  = 16,
  parameter int ADDR_WD     = 32,
  parameter int MEM_DATA_WD = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WD-1:0]     req_addr,
  input  logic                   flush,
  input  logic                   inv,
  output logic                   inv_done,
  output logic                   resp_valid,
  output logic [31:0]            resp_data,
  output logic                   cache_miss,
  output logic                   mem_req,
  input  logic                   mem_ready,
  output logic [ADDR_WD-1:0]     mem_addr,
  input  logic                   mem_valid,
  input  logic [MEM_DATA_WD-1:0] mem_rdata
);

  localparam int BEATS  = LINE_BYTES * 8 / MEM_DATA_WD;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WD - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WPL    = LINE_BYTES / 4;
  localparam int WSEL_W = (WPL > 1) ? $clog2(WPL) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MISS   = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_FILL   = 2'd3;

  logic [TAG_W-1:0]   r_tag   [WAYS][SETS];
  logic [LINE_W-1:0]  r_data  [WAYS][SETS];
  logic [SETS-1:0]    r_valid [WAYS];

  logic [1:0]         r_state;
  logic               r_s1_valid;
  logic [ADDR_WD-1:0] r_s1_addr;
  logic [ADDR_WD-1:0] r_miss_addr;
  logic               r_mem_req;
  logic [ADDR_WD-1:0] r_mem_addr;
  logic [BEAT_W-1:0]  r_beat;
  logic [LINE_W-1:0]  r_buf;
  logic               r_kill;
  logic               r_inv_done;

  logic [IDX_W-1:0]   w_s1_idx, w_m_idx;
  logic [TAG_W-1:0]   w_s1_tag, w_m_tag;
  logic [WAYS-1:0]    w_hit_vec;
  logic [WAY_W-1:0]   w_hit_way, w_victim, w_policy;
  logic [LINE_W-1:0]  w_hit_line;
  logic               w_idle, w_fill, w_s2_miss, w_hit_resp, w_fill_resp;
  logic               w_accept, w_inv_go, w_found;
  logic [31:0]        w_word;

  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                           input logic [ADDR_WD-1:0] a);
    logic [WSEL_W-1:0] s;
    s = WSEL_W'(a >> 2);
    if (WPL == 1) s = '0;
    return line[32*s +: 32];
  endfunction

  assign w_s1_idx = r_s1_addr[OFF_W +: IDX_W];
  assign w_s1_tag = r_s1_addr[ADDR_WD-1 -: TAG_W];
  assign w_m_idx  = r_miss_addr[OFF_W +: IDX_W];
  assign w_m_tag  = r_miss_addr[ADDR_WD-1 -: TAG_W];

  always_comb begin
    w_hit_vec  = '0;
    w_hit_way  = '0;
    w_hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w][w_s1_idx] && (r_tag[w][w_s1_idx] == w_s1_tag);
      if (w_hit_vec[w]) begin
        w_hit_way  = WAY_W'(w);
        w_hit_line = w_hit_line | r_data[w][w_s1_idx];
      end
    end
  end

  assign w_idle      = (r_state == S_IDLE);
  assign w_fill      = (r_state == S_FILL);
  assign w_s2_miss   = r_s1_valid && !flush && !(|w_hit_vec);
  assign w_hit_resp  = r_s1_valid && !flush && (|w_hit_vec);
  assign w_fill_resp = w_fill && !r_kill && !flush;
  assign w_accept    = req_valid && req_ready && !flush;
  // S1 must be drained before the invalidate so no lookup straddles it.
  assign w_inv_go    = inv && w_idle && !r_s1_valid && !r_inv_done;
  assign w_word      = sel_word(w_fill ? r_buf : w_hit_line,
                                w_fill ? r_miss_addr : r_s1_addr);

  assign req_ready  = w_idle && !w_s2_miss && !inv;
  assign resp_valid = w_hit_resp || w_fill_resp;
  assign resp_data  = resp_valid ? w_word : 32'd0;
  assign cache_miss = w_s2_miss || !w_idle;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign inv_done   = r_inv_done;

  always_comb begin
    w_victim = w_policy;
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !r_valid[w][w_m_idx]) begin
        w_victim = WAY_W'(w);
        w_found  = 1'b1;
      end
    end
  end

`ifdef YSYX_22041752_ICACHE_PLRU_EN
  localparam int PL_W  = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int LOG_W = $clog2(WAYS);

  logic [PL_W-1:0] r_plru [SETS];

  // Each node bit names the child subtree holding the next victim.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] t);
    int node;
    node = 0;
    for (int n = 0; n < PL_W; n++)
      if (WAYS > 1 && n == node) node = 2 * n + 1 + (t[n] ? 1 : 0);
    return (WAYS > 1) ? WAY_W'(node - (WAYS - 1)) : '0;
  endfunction

  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] t,
                                                 input logic [WAY_W-1:0] way);
    int   node, lvl;
    logic d;
    node = 0;
    lvl  = LOG_W - 1;
    for (int n = 0; n < PL_W; n++) begin
      if (WAYS > 1 && n == node) begin
        d    = |((way >> lvl) & WAY_W'(1));
        t[n] = ~d;
        node = 2 * n + 1 + (d ? 1 : 0);
        lvl  = lvl - 1;
      end
    end
    return t;
  endfunction

  assign w_policy = plru_victim(r_plru[w_m_idx]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else if (w_fill) begin
      r_plru[w_m_idx] <= plru_touch(r_plru[w_m_idx], w_victim);
    end else if (w_hit_resp) begin
      r_plru[w_s1_idx] <= plru_touch(r_plru[w_s1_idx], w_hit_way);
    end
  end
`else
  logic [WAY_W-1:0] r_rr;

  assign w_policy = r_rr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rr <= '0;
    else if (w_fill) r_rr <= (WAYS == 1) ? '0 : r_rr + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_miss_addr <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_beat      <= '0;
      r_buf       <= '0;
      r_kill      <= 1'b0;
      r_inv_done  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1_addr <= req_addr;
      r_inv_done <= w_inv_go;
      case (r_state)
        S_IDLE: begin
          if (w_s2_miss) begin
            r_state     <= S_MISS;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= {r_s1_addr[ADDR_WD-1:OFF_W], {OFF_W{1'b0}}};
            r_miss_addr <= r_s1_addr;
            r_kill      <= 1'b0;
          end
        end
        S_MISS: begin
          if (flush) r_kill <= 1'b1;
          if (mem_ready) begin
            r_state   <= S_REFILL;
            r_mem_req <= 1'b0;
          end
        end
        S_REFILL: begin
          if (flush) r_kill <= 1'b1;
          if (mem_valid) begin
            r_buf[r_beat*MEM_DATA_WD +: MEM_DATA_WD] <= mem_rdata;
            if (r_beat == BEAT_W'(BEATS - 1)) begin
              r_beat  <= '0;
              r_state <= S_FILL;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
    end else if (w_inv_go) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
    end else if (w_fill) begin
      r_valid[w_victim][w_m_idx] <= 1'b1;
    end
  end

  // Tag/data carry no reset: the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_victim][w_m_idx]  <= w_m_tag;
      r_data[w_victim][w_m_idx] <= r_buf;
    end
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22041752_icache_sa.md
# ysyx_22041752_icache_sa

Parametrised N-way set-associative instruction cache: the successor to the fixed 2-way, 64-set, 128-bit-line ICACHE between IFU and the SRAM/AXI bridge. Arrays are internal register-file storage, not hard SRAM macros. It adds configurable geometry, a refill FSM with multi-beat bursts, per-set replacement state and a whole-cache invalidate for `fence.i`.

## Interface
- `WAYS`, 2, associativity; power of two, 1..8
- `SETS`, 64, sets per way; power of two, ≥2
- `LINE_BYTES`, 16, line size; power of two, ≥ `MEM_DATA_WD`/8
- `ADDR_WD`, 32, fetch address width
- `MEM_DATA_WD`, 64, refill beat width; `BEATS` = `LINE_BYTES`*8/`MEM_DATA_WD`
- `clk` in 1: the single clock; all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: fetch request
- `req_ready` out 1: request accepted when `req_valid`&&`req_ready`
- `req_addr` in `ADDR_WD`: fetch address, word aligned
- `flush` in 1: kill the pending response (pipeline redirect)
- `inv` in 1: invalidate all lines (level; held until `inv_done`)
- `inv_done` out 1: one-cycle pulse, invalidate performed
- `resp_valid` out 1: instruction valid, one-cycle pulse
- `resp_data` out 32: instruction word
- `cache_miss` out 1: high while a miss is outstanding
- `mem_req` out 1: line refill request, held until `mem_ready`
- `mem_ready` in 1: memory accepts request
- `mem_addr` out `ADDR_WD`: line-aligned refill address
- `mem_valid` in 1: refill beat valid
- `mem_rdata` in `MEM_DATA_WD`: refill beat data

## Operation
- Address split: offset = low log2(`LINE_BYTES`) bits (word select = offset[msb:2]); index = next log2(`SETS`) bits; tag = the remaining bits.
- Two stages. S1: accept request, read all ways' tag/valid/data at the index. S2: compare; hit = any way valid with matching tag.
- FSM: IDLE → MISS (S2 miss; `mem_req`=1) → REFILL (on `mem_ready`) → FILL (after beat `BEATS`-1) → IDLE.
- REFILL: beats are counted from 0. Beat k is written to line bits [k*`MEM_DATA_WD` +: `MEM_DATA_WD`]. `mem_valid` is ignored outside REFILL.
- FILL: the victim way's data, tag and valid=1 are written in one cycle. The requested word is forwarded from the refill buffer as `resp_valid`.
- Victim selection: the lowest-index invalid way. If every way is valid, the replacement policy chooses (see Configuration).
- Replacement state is updated on every hit and every fill.
- `flush`:
  - Clears a valid S1 entry and suppresses a hit response in the same cycle.
  - During MISS/REFILL/FILL the refill still completes and the line is written, but `resp_valid` is suppressed.
- `inv`:
  - Acts only in IDLE with S1 empty. `req_ready`=0 while `inv`=1.
  - Clears all valid bits in one cycle, then pulses `inv_done` the next cycle.
  - Replacement state is not cleared.
- Reset values: `req_ready`=1 (IDLE); `resp_valid`, `resp_data`, `cache_miss`, `mem_req`, `mem_addr`, `inv_done` all 0. All valid bits, replacement state and the beat counter are 0. Reset mid-refill abandons the refill and writes no line.

## Timing
- `req_ready` = IDLE && !S2-miss && !`inv`.
- Hit: accepted at cycle T → `resp_valid` at T+1. Back-to-back hits sustain 1 per cycle.
- Miss accepted at T:
  - `cache_miss`=1 from T+1 until the FILL cycle inclusive.
  - `mem_req` and `mem_addr` are registered, valid from T+2.
- Last beat at cycle B → FILL and `resp_valid` at B+1 → `req_ready`=1 at B+2.
- A request arriving while `flush`=1 in the same cycle is not accepted.
- There is no response backpressure: the consumer takes `resp_valid` unconditionally.

## Configuration
- `YSYX_22041752_ICACHE_PLRU_EN` defined: each set keeps a tree-PLRU of `WAYS`-1 bits. The victim is the way the tree points to.
- Not defined: a global log2(`WAYS`)-bit round-robin counter, incremented on every fill (invalid-way fills included). The victim is the counter value.

## Test plan
Defaults apply, so `BEATS`=2.
- Cold miss 0x8000_0004:
  - `mem_req` with `mem_addr`=0x8000_0000.
  - Beats 0x11112222_33334444, 0x55556666_77778888 → `resp_data`=0x11112222.
  - A re-fetch of 0x8000_0004 hits, with `resp_valid` on the next cycle and no `mem_req`.
- Replacement:
  - Sequence: fill 0x8000_0000 (way0), fill 0x8000_0400 (way1), hit 0x8000_0000, then miss 0x8000_0800.
  - With PLRU enabled, way1 is evicted, so 0x8000_0000 still hits and 0x8000_0400 misses.
  - Without PLRU, way0 is evicted.
- Hit stream: 4 consecutive requests 0x8000_0000..0x8000_000C on a filled line → 4 consecutive `resp_valid` pulses with matching words.
- Flush during REFILL: the line is written, `resp_valid` never rises, and a later fetch of the same address hits.
- `inv` after two fills → `inv_done` pulse. Both addresses then miss, and `req_ready` is 0 while `inv` is high.
- Drop `reset_n` between refill beats:
  - All outputs go to their reset values immediately.
  - After release, the address that was being refilled misses.
